// File: rtl/portmux_pkg.sv
// ============================================================================
// Module  : portmux_pkg
// Brief   : Requester codes, default sizes and the read-tag type shared by portdemux.
// Revision: 1.0
// ============================================================================
`default_nettype none

package portmux_pkg;

  localparam int DEFAULT_W = 128;
  localparam int DEFAULT_L = 2;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_IC   = 2'd1,
    REQ_MVU  = 2'd2,
    REQ_CTRL = 2'd3
  } req_code_t;

  typedef struct packed {
    req_code_t code;
    logic      v;
  } tag_t;

  // Fixed priority IC > MVU > Ctrl; writes still carry a code but never a valid bit.
  function automatic tag_t make_tag(input logic ic, input logic mvu,
                                    input logic ctrl, input logic we);
    tag_t t;
    if (ic)        t.code = REQ_IC;
    else if (mvu)  t.code = REQ_MVU;
    else if (ctrl) t.code = REQ_CTRL;
    else           t.code = REQ_NONE;
    t.v = (ic | mvu | ctrl) & ~we;
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/portdemux_tagpipe.sv
// ============================================================================
// Module  : portdemux_tagpipe
// Brief   : l-stage shift register of read tags, advancing every cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module portdemux_tagpipe
  import portmux_pkg::*;
#(
  parameter int l = DEFAULT_L
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tail,
  output logic busy
);

  tag_t [l-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < l; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tail = stage[l-1];

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < l; i++) begin
      busy = busy | stage[i].v;
    end
  end

endmodule

`default_nettype wire

// File: rtl/portdemux.sv
// ============================================================================
// Module  : portdemux
// Brief   : Routes memory read data back to the IC/MVU/Ctrl requester that was
//           granted l cycles earlier. Define PORTDEMUX_BYPASS_EN for a
//           combinational return path instead of the registered one.
// Revision: 1.0
// ============================================================================
`default_nettype none

module portdemux
  import portmux_pkg::*;
#(
  parameter int w = DEFAULT_W,
  parameter int l = DEFAULT_L
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         grntIC,
  input  logic         grntMVU,
  input  logic         grntCtrl,
  input  logic         we,
  input  logic [w-1:0] rdData,
  output logic [w-1:0] dataIC,
  output logic [w-1:0] dataMVU,
  output logic [w-1:0] dataCtrl,
  output logic         validIC,
  output logic         validMVU,
  output logic         validCtrl,
  output logic         busy,
  output logic         errOverlap,
  output logic [15:0]  rdCount
);

  tag_t tag_in;
  tag_t tail;
  logic overlap;

  assign tag_in  = make_tag(grntIC, grntMVU, grntCtrl, we);
  assign overlap = (grntIC & grntMVU) | (grntIC & grntCtrl) | (grntMVU & grntCtrl);

  portdemux_tagpipe #(
    .l (l)
  ) u_tagpipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_in (tag_in),
    .tail   (tail),
    .busy   (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errOverlap <= 1'b0;
      rdCount    <= 16'd0;
    end else begin
      if (overlap) errOverlap <= 1'b1;
      if (tail.v)  rdCount    <= rdCount + 16'd1;
    end
  end

`ifdef PORTDEMUX_BYPASS_EN

  always_comb begin
    validIC   = tail.v && (tail.code == REQ_IC);
    validMVU  = tail.v && (tail.code == REQ_MVU);
    validCtrl = tail.v && (tail.code == REQ_CTRL);
    dataIC    = validIC   ? rdData : '0;
    dataMVU   = validMVU  ? rdData : '0;
    dataCtrl  = validCtrl ? rdData : '0;
  end

`else

  // Data registers only load on their own return, so other requesters hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validIC   <= 1'b0;
      validMVU  <= 1'b0;
      validCtrl <= 1'b0;
      dataIC    <= '0;
      dataMVU   <= '0;
      dataCtrl  <= '0;
    end else begin
      validIC   <= 1'b0;
      validMVU  <= 1'b0;
      validCtrl <= 1'b0;
      if (tail.v) begin
        case (tail.code)
          REQ_IC: begin
            validIC <= 1'b1;
            dataIC  <= rdData;
          end
          REQ_MVU: begin
            validMVU <= 1'b1;
            dataMVU  <= rdData;
          end
          REQ_CTRL: begin
            validCtrl <= 1'b1;
            dataCtrl  <= rdData;
          end
          default: ;
        endcase
      end
    end
  end

`endif

endmodule

`default_nettype wire

// File: tb/tb_portdemux.sv
// ============================================================================
// Module  : tb_portdemux
// Brief   : Self-checking bench for portdemux (l=2), registered or bypass build.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_portdemux;
  import portmux_pkg::*;

  localparam int W = 128;
  localparam int L = 2;
`ifdef PORTDEMUX_BYPASS_EN
  localparam int LAT = L;
`else
  localparam int LAT = L + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         grntIC = 1'b0, grntMVU = 1'b0, grntCtrl = 1'b0, we = 1'b0;
  logic [W-1:0] rdData = '0;
  logic [W-1:0] dataIC, dataMVU, dataCtrl;
  logic         validIC, validMVU, validCtrl, busy, errOverlap;
  logic [15:0]  rdCount;

  portdemux #(.w(W), .l(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .grntIC     (grntIC),
    .grntMVU    (grntMVU),
    .grntCtrl   (grntCtrl),
    .we         (we),
    .rdData     (rdData),
    .dataIC     (dataIC),
    .dataMVU    (dataMVU),
    .dataCtrl   (dataCtrl),
    .validIC    (validIC),
    .validMVU   (validMVU),
    .validCtrl  (validCtrl),
    .busy       (busy),
    .errOverlap (errOverlap),
    .rdCount    (rdCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   code;
    logic [W-1:0] data;
    int           issue;
  } exp_t;

  typedef struct {
    logic         gi, gm, gc, wr;
    logic [W-1:0] ret;
    int           at;
  } vec_t;

  exp_t         expq[$];
  int           cnt_q[$];
  logic [W-1:0] rd_at[int];
  logic [W-1:0] exp_hold[4];
  logic [15:0]  exp_cnt = 16'd0;
  int           err_cycle = -1;
  int           cyc = 0;
  int           tests = 0;
  int           failed = 0;
  bit           mon_en = 1'b0;

  logic         m_busy;
  logic [2:0]   m_ev;
  logic [W-1:0] m_ed[4];
  exp_t         m_e;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drive one cycle of grants; rdData carries the data due for the read issued L cycles ago.
  task automatic step(input logic gi, input logic gm, input logic gc, input logic wr,
                      input logic [W-1:0] ret);
    exp_t e;
    grntIC = gi; grntMVU = gm; grntCtrl = gc; we = wr;
    if (rd_at.exists(cyc)) begin
      rdData = rd_at[cyc];
      rd_at.delete(cyc);
    end else begin
      rdData = rand_data();
    end
    if ((gi | gm | gc) && !wr) begin
      e.code  = gi ? 2'd1 : (gm ? 2'd2 : 2'd3);
      e.data  = ret;
      e.issue = cyc;
      expq.push_back(e);
      rd_at[cyc + L] = ret;
    end
    if (((gi & gm) | (gi & gc) | (gm & gc)) && err_cycle < 0) err_cycle = cyc;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    grntIC = 1'b0; grntMVU = 1'b0; grntCtrl = 1'b0; we = 1'b0;
    #1;
    chk("rst_valid", W'({validCtrl, validMVU, validIC}), '0);
    chk("rst_dataIC", dataIC, '0);
    chk("rst_dataMVU", dataMVU, '0);
    chk("rst_dataCtrl", dataCtrl, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_err", W'(errOverlap), '0);
    chk("rst_count", W'(rdCount), '0);
    expq.delete(); cnt_q.delete(); rd_at.delete();
    for (int i = 0; i < 4; i++) exp_hold[i] = '0;
    exp_cnt = 16'd0;
    err_cycle = -1;
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard: pops the expected return whose due cycle matches, checks all outputs.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      m_busy = 1'b0;
      foreach (expq[i]) if (expq[i].issue >= cyc - L && expq[i].issue < cyc) m_busy = 1'b1;
      chk("busy", W'(busy), W'(m_busy));
      m_ev = 3'b000;
      for (int x = 0; x < 4; x++) begin
`ifdef PORTDEMUX_BYPASS_EN
        m_ed[x] = '0;
`else
        m_ed[x] = exp_hold[x];
`endif
      end
      if (expq.size() > 0 && expq[0].issue + LAT == cyc) begin
        m_e = expq.pop_front();
        m_ev[int'(m_e.code) - 1] = 1'b1;
        m_ed[m_e.code] = m_e.data;
        exp_hold[m_e.code] = m_e.data;
        cnt_q.push_back(m_e.issue + L + 1);
      end
      while (cnt_q.size() > 0 && cnt_q[0] <= cyc) begin
        void'(cnt_q.pop_front());
        exp_cnt = exp_cnt + 16'd1;
      end
      chk("valid", W'({validCtrl, validMVU, validIC}), W'(m_ev));
      chk("dataIC", dataIC, m_ed[1]);
      chk("dataMVU", dataMVU, m_ed[2]);
      chk("dataCtrl", dataCtrl, m_ed[3]);
      chk("rdCount", W'(rdCount), W'(exp_cnt));
      chk("errOverlap", W'(errOverlap), W'(err_cycle >= 0 && cyc > err_cycle));
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    failed++;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[9];
    int   k;
    logic [1:0] pick;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 128'hA5, 10};                 // MVU read
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 128'h1111_0000_2222_0001, 20}; // IC stream
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 128'hC0FFEE_0002, 21};        // Ctrl stream
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 128'hBEEF_0003, 22};          // MVU stream
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 128'hDEAD, 40};               // IC write
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 128'h5A5A_5A5A, 50};          // IC+Ctrl overlap read
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, {4{32'hFFFF_FFFF}}, 60};      // all three -> IC
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 128'h0, 61};                  // overlap write
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 128'h8000_0000_0000_0001, 62};// MVU+Ctrl -> MVU

    do_reset(2);
    mon_en = 1'b1;

    foreach (tbl[i]) begin
      while (cyc < tbl[i].at) idle(1);
      step(tbl[i].gi, tbl[i].gm, tbl[i].gc, tbl[i].wr, tbl[i].ret);
    end
    idle(6);
    chk("err_sticky", W'(errOverlap), W'(1));
    chk("count_after_table", W'(rdCount), W'(7));

    // Reset one cycle after a read: it must vanish, then the first new grant is tracked.
    step(1'b1, 1'b0, 1'b0, 1'b0, 128'h77);
    do_reset(1);
    idle(5);
    chk("midflight_busy", W'(busy), '0);
    chk("midflight_count", W'(rdCount), '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 128'h3C3C);
    idle(5);
    chk("first_after_reset", W'(rdCount), W'(1));

    // Back-to-back reads up to the counter wrap.
    do_reset(2);
    for (k = 0; k < 65535; k++) begin
      pick = 2'($urandom_range(1, 3));
      step(pick == 2'd1, pick == 2'd2, pick == 2'd3, 1'b0, rand_data());
    end
    idle(4);
    chk("count_ffff", W'(rdCount), W'(16'hFFFF));
    step(1'b1, 1'b0, 1'b0, 1'b0, 128'h1234);
    idle(4);
    chk("count_wrap", W'(rdCount), '0);
    chk("queue_drained", W'(expq.size()), '0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
